// File: rtl/imem_uart_loader.sv
// imem_uart_loader: UART boot loader that fills the 256-word instruction RAM while holding the CPU in reset.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module imem_uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic        imem_we,
  output logic [7:0]  imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int TO = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TO + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, DONE} state_t;
  state_t state_q, state_d;
  logic rx1_q, rx2_q, rx3_q, busy_q;
  logic [CW-1:0] bcnt_q;
  logic [3:0] bit_q;
  logic [7:0] sh_q;
  logic [TW-1:0] tmo_q;
  logic [7:0] n_q, n_d, addr_q, addr_d, csum_q, csum_d, waddr_q, waddr_d;
  logic [31:0] word_q, word_d, wdata_q, wdata_d;
  logic [1:0] bidx_q, bidx_d;
  logic we_q, we_d, hold_q, hold_d, done_q, done_d, err_q, err_d;
  logic start_edge, tick, byte_valid, frame_err, active, timeout;
  assign start_edge = ~busy_q & rx3_q & ~rx2_q;
  assign tick       = busy_q && bcnt_q == ((bit_q == 4'd0) ? HALF : FULL);
  assign byte_valid = tick && bit_q == 4'd9 && rx2_q;
  assign frame_err  = tick && bit_q == 4'd9 && !rx2_q;
  assign active     = state_q == COUNT || state_q == DATA || state_q == CHECK;
  assign timeout    = active && !start_edge && tmo_q == TW'(TO);
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    addr_d  = addr_q;
    word_d  = word_q;
    bidx_d  = bidx_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          done_d = 1'b1;
          hold_d = 1'b0;
        end
        if (byte_valid && sh_q == 8'hA5) begin
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          addr_d  = '0;
          csum_d  = '0;
          bidx_d  = '0;
          state_d = COUNT;
        end
      end
      COUNT: if (byte_valid) begin
        n_d     = sh_q;
        state_d = DATA;
      end
      DATA: if (byte_valid) begin
        word_d = {word_q[23:0], sh_q};
        csum_d = csum_q ^ sh_q;
        bidx_d = bidx_q + 2'd1;
        if (bidx_q == 2'd3) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = word_d;
          addr_d  = addr_q + 8'd1;
          // N==0 encodes 256 words: the last address then wraps to zero
          if (addr_q + 8'd1 == n_q)
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: if (byte_valid) begin
        state_d = (sh_q == csum_q) ? DONE : IDLE;
        done_d  = sh_q == csum_q;
        hold_d  = sh_q != csum_q;
        err_d   = sh_q != csum_q;
      end
`endif
      default: state_d = IDLE;
    endcase
    if (active && (frame_err || timeout)) begin
      err_d   = 1'b1;
      hold_d  = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx1_q   <= 1'b1;
      rx2_q   <= 1'b1;
      rx3_q   <= 1'b1;
      busy_q  <= 1'b0;
      bcnt_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tmo_q   <= '0;
      state_q <= IDLE;
      n_q     <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      bidx_q  <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rx1_q <= uart_rx;
      rx2_q <= rx1_q;
      rx3_q <= rx2_q;
      if (start_edge) begin
        busy_q <= 1'b1;
        bcnt_q <= CW'(1);
        bit_q  <= '0;
      end else if (tick) begin
        bcnt_q <= CW'(1);
        bit_q  <= bit_q + 4'd1;
        if ((bit_q == 4'd0 && rx2_q) || bit_q == 4'd9) busy_q <= 1'b0;
        if (bit_q != 4'd0 && bit_q != 4'd9) sh_q <= {rx2_q, sh_q[7:1]};
      end else if (busy_q) begin
        bcnt_q <= bcnt_q + CW'(1);
      end
      tmo_q   <= (!active || start_edge) ? '0 : tmo_q + TW'(1);
      state_q <= state_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      bidx_q  <= bidx_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = hold_q;
  assign load_done  = done_q;
  assign load_error = err_q;
endmodule

// File: tb/tb_imem_uart_loader.sv
// tb_imem_uart_loader: frame table plus corner-case sequences, write strobes checked against a scoreboard queue.
module tb_imem_uart_loader;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, uart_rx = 1'b1;
  logic imem_we, cpu_hold, load_done, load_error;
  logic [7:0] imem_waddr;
  logic [31:0] imem_wdata;
  typedef struct packed {logic [7:0] a; logic [31:0] d;} wr_t;
  typedef struct {logic [31:0] w0, w1; logic [7:0] cx; logic done, err, hold;} vec_t;
  wr_t exp_q[$];
  logic [31:0] wq[$];
  vec_t tbl[4];
  int tests = 0, fails = 0, n_we = 0;
  logic [7:0] last_addr = '0;
  logic we_prev = 1'b0;
  imem_uart_loader #(.CLKS_PER_BIT(4), .TIMEOUT_BITS(32)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      wr_t e;
      n_we++;
      last_addr = imem_waddr;
      chk("we_single_cycle", {31'd0, we_prev}, 32'd0);
      if (exp_q.size() == 0) chk("unexpected_strobe", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("waddr", {24'd0, imem_waddr}, {24'd0, e.a});
        chk("wdata", imem_wdata, e.d);
      end
    end
    we_prev = imem_we;
  end
  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (4) @(negedge clk);
    end
    uart_rx = stop;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    if (!stop) repeat (4) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] n, input logic [7:0] cx);
    logic [7:0] cs = '0;
    logic [31:0] w;
    send_byte(8'hA5, 1'b1);
    send_byte(n, 1'b1);
    foreach (wq[i]) begin
      w = wq[i];
      exp_q.push_back('{8'(i), w});
      for (int k = 3; k >= 0; k--) begin
        send_byte(w[8*k+:8], 1'b1);
        cs ^= w[8*k+:8];
      end
    end
    if (CHK) send_byte(cs ^ cx, 1'b1);
    repeat (12) @(negedge clk);
  endtask
  task automatic chk_out(input string tag, input logic done, input logic err, input logic hold);
    chk({tag, "_done"}, {31'd0, load_done}, {31'd0, done});
    chk({tag, "_error"}, {31'd0, load_error}, {31'd0, err});
    chk({tag, "_hold"}, {31'd0, cpu_hold}, {31'd0, hold});
  endtask
  initial begin
    int n0;
    tbl[0] = '{32'h241D0100, 32'h24040000, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{32'h241D0100, 32'h24040000, 8'h01, CHK ? 1'b0 : 1'b1, CHK, CHK};
    tbl[2] = '{32'h241D0100, 32'h24040000, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{32'hDEADBEEF, 32'h00000013, 8'h00, 1'b1, 1'b0, 1'b0};
    repeat (3) @(negedge clk);
    chk_out("reset", 1'b0, 1'b0, 1'b1);
    chk("reset_we", {31'd0, imem_we}, 32'd0);
    chk("reset_waddr", {24'd0, imem_waddr}, 32'd0);
    chk("reset_wdata", imem_wdata, 32'd0);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("idle_no_strobe", n_we, 0);
    chk_out("idle", 1'b0, 1'b0, 1'b1);
    for (int t = 0; t < 4; t++) begin
      wq = '{tbl[t].w0, tbl[t].w1};
      send_frame(8'd2, tbl[t].cx);
      chk_out($sformatf("frame%0d", t), tbl[t].done, tbl[t].err, tbl[t].hold);
      chk($sformatf("frame%0d_pending", t), exp_q.size(), 0);
    end
    send_byte(8'h00, 1'b1);
    send_byte(8'h5A, 1'b1);
    repeat (12) @(negedge clk);
    chk_out("junk", 1'b1, 1'b0, 1'b0);
    wq.delete();
    for (int i = 0; i < 256; i++) wq.push_back($urandom);
    n0 = n_we;
    send_frame(8'd0, 8'h00);
    chk("full_strobes", n_we - n0, 256);
    chk("full_last_addr", {24'd0, last_addr}, 32'd255);
    chk("full_pending", exp_q.size(), 0);
    chk_out("full", 1'b1, 1'b0, 1'b0);
    n0 = n_we;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h24, 1'b1);
    repeat (10) @(negedge clk);
    chk_out("pre_timeout", 1'b0, 1'b0, 1'b1);
    repeat (200) @(negedge clk);
    chk_out("timeout", 1'b0, 1'b1, 1'b1);
    chk("timeout_no_strobe", n_we - n0, 0);
    wq = '{32'h12345678};
    send_frame(8'd1, 8'h00);
    chk_out("after_timeout", 1'b1, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h24, 1'b0);
    repeat (12) @(negedge clk);
    chk_out("frame_err", 1'b0, 1'b1, 1'b1);
    wq = '{32'hCAFEF00D, 32'h0BADC0DE};
    send_frame(8'd2, 8'h00);
    chk_out("pre_reset", 1'b1, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h24, 1'b1);
    send_byte(8'h1D, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_out("mid_reset", 1'b0, 1'b0, 1'b1);
    chk("mid_reset_we", {31'd0, imem_we}, 32'd0);
    chk("mid_reset_waddr", {24'd0, imem_waddr}, 32'd0);
    chk("mid_reset_wdata", imem_wdata, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    wq = '{32'h00000093, 32'hFFFFFFFF};
    send_frame(8'd2, 8'h00);
    chk_out("post_reset", 1'b1, 1'b0, 1'b0);
    chk("post_reset_pending", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
